inc_strobe_tx: RTL and testbench

- Transmit side of the increment-strobe interface: accepts a request for N increments and drives a train of single-cycle increment strobes into a strobe-counting receiver.
- Receiver counts on the rising edge of the strobe, so every strobe is separated by at least one low cycle.
- Keeps a local wrapping mirror of the receiver's count so the bench and the upstream logic can check delivery without reading the receiver.

---
 rtl/inc_pkg.sv | 18 +
 rtl/inc_gap_timer.sv | 39 +++
 rtl/inc_strobe_tx.sv | 114 +++++++++++
 tb/tb_inc_strobe_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inc_pkg.sv
// Shared definitions for the increment-strobe transmitter and its receiver.
package inc_pkg;

    // Transmitter sequencing states.
    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap,
        StDone
    } inc_state_e;

    // Smallest legal number of low cycles between strobes.
    localparam int unsigned GAP_MIN   = 1;
    // Default widths, kept in step with the receiver.
    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned OUT_W_DEF = 2;

endpackage

// File: rtl/inc_gap_timer.sv
// Loadable down-counter timing the low phase between strobes.
module inc_gap_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] count_q, count_d;

    // Next count: load wins over decrement; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    // Flags the final cycle of the gap, so the caller can leave at that edge.
    assign expired = (count_q == W'(1));

endmodule

// File: rtl/inc_strobe_tx.sv
// Transmit side of the increment-strobe interface: turns a request for N
// increments into N single-cycle strobes separated by GAP low cycles, and
// keeps a wrapping mirror of the receiver's count.
module inc_strobe_tx
    import inc_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned GAP   = 1,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_count,
    output logic             req_ready,
    output logic             inc_strobe,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] sent_count
);

    localparam int unsigned GapW = 4;

    if ((GAP < GAP_MIN) || (GAP > 15)) begin : g_bad_gap
        $error("inc_strobe_tx: GAP must be in 1..15");
    end

    inc_state_e       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             strobe_q, busy_q, done_q;
    logic [OUT_W-1:0] sent_q;

    logic             tmr_load, tmr_dec, tmr_expired;
    logic [GapW-1:0]  tmr_count;

    inc_gap_timer #(
        .W (GapW)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (GapW'(GAP)),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .expired  (tmr_expired)
    );

    // Next-state, remaining-count and gap-timer control.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_count != '0) begin
                        rem_d   = req_count;
                        state_d = StPulse;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StPulse: begin
                // PULSE is only entered with rem_q > 0, so this cannot wrap.
                rem_d    = rem_q - CNT_W'(1);
                tmr_load = 1'b1;
                state_d  = StGap;
            end
            StGap: begin
                tmr_dec = 1'b1;
                if (tmr_expired) begin
                    state_d = (rem_q != '0) ? StPulse : StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; outputs are decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            strobe_q <= (state_d == StPulse);
            busy_q   <= (state_d == StPulse) || (state_d == StGap);
            done_q   <= (state_d == StDone);
            if (state_q == StPulse) begin
                sent_q <= sent_q + OUT_W'(1);
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign inc_strobe = strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = sent_q;

endmodule

// File: tb/tb_inc_strobe_tx.sv
// Scoreboard bench for inc_strobe_tx: stimulus pushes expected strobe/done
// events and per-cycle status snapshots; one monitor pops and compares.
module tb_inc_strobe_tx;

    logic       clk;
    logic       rst;
    logic [1:0] rv;
    logic [3:0] rc;
    logic [1:0] rdy, strb, dn, bsy;
    logic [1:0] sent_a, sent_b;

    // Instance 0: GAP=1, instance 1: GAP=3.
    inc_strobe_tx #(.CNT_W(4), .GAP(1), .OUT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (rv[0]),
        .req_count  (rc),
        .req_ready  (rdy[0]),
        .inc_strobe (strb[0]),
        .busy       (bsy[0]),
        .done       (dn[0]),
        .sent_count (sent_a)
    );

    inc_strobe_tx #(.CNT_W(4), .GAP(3), .OUT_W(2)) dut_g3 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (rv[1]),
        .req_count  (rc),
        .req_ready  (rdy[1]),
        .inc_strobe (strb[1]),
        .busy       (bsy[1]),
        .done       (dn[1]),
        .sent_count (sent_b)
    );

    typedef struct {
        int cyc;
        int id;
        bit is_done;
        int sent;
    } ev_t;

    typedef struct {
        int cyc;
        int id;
        bit ready;
        bit busy;
        bit strobe;
        bit done;
        int sent;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];

    int  edge_n = 0;
    int  n_vec  = 0;
    int  n_miss = 0;
    bit  end_req = 1'b0;
    int  base[2];
    int  rx[2];
    bit  prev_strb[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_status(input int id, input bit r, input bit b, input bit s,
                                 input bit d, input int sent);
        st_t e;
        e.cyc = edge_n + 1; e.id = id; e.ready = r; e.busy = b;
        e.strobe = s; e.done = d; e.sent = sent;
        st_q.push_back(e);
    endtask

    task automatic push_ev(input int cyc, input int id, input bit is_done, input int sent);
        ev_t e;
        e.cyc = cyc; e.id = id; e.is_done = is_done; e.sent = sent;
        ev_q.push_back(e);
    endtask

    // Strobes and done for an accept of n at edge t on instance id.
    task automatic push_train(input int id, input int t, input int n, input int gap);
        for (int k = 0; k < n; k++) push_ev(t + 1 + k * (gap + 1), id, 1'b0, (base[id] + k) % 4);
        push_ev(t + n * (gap + 1) + 1, id, 1'b1, (base[id] + n) % 4);
        base[id] = (base[id] + n) % 4;
    endtask

    task automatic request(input int id, input int n, input int gap);
        int t;
        int old;
        old    = base[id];
        rc     = 4'(n);
        rv[id] = 1'b1;
        t      = edge_n + 1;
        push_train(id, t, n, gap);
        tick(1);
        rv[id] = 1'b0;
        expect_status(id, 1'b0, n > 0, n > 0, n == 0, old);
        if (n > 0) begin
            tick(1);
            expect_status(id, 1'b0, 1'b1, 1'b0, 1'b0, (old + 1) % 4);
            tick(n * (gap + 1) - 1);
            expect_status(id, 1'b0, 1'b0, 1'b0, 1'b1, base[id]);
        end
        tick(1);
        expect_status(id, 1'b1, 1'b0, 1'b0, 1'b0, base[id]);
    endtask

    initial begin
        int t;
        int old;
        rst  = 1'b1;
        rv   = '0;
        rc   = '0;
        base[0] = 0;
        base[1] = 0;
        tick(2);
        expect_status(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        expect_status(1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        tick(1);

        // Single increment.
        request(0, 1, 1);

        // Fresh start so the wrap train ends with the receiver at 1.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        base[0] = 0;
        base[1] = 0;
        tick(1);
        request(0, 5, 1);

        // Zero count, then back-pressure with valid held high.
        old   = base[0];
        rc    = 4'd0;
        rv[0] = 1'b1;
        t     = edge_n + 1;
        push_ev(t + 1, 0, 1'b1, old);
        tick(1);
        rc = 4'd3;
        expect_status(0, 1'b0, 1'b0, 1'b0, 1'b1, old);
        tick(1);
        expect_status(0, 1'b1, 1'b0, 1'b0, 1'b0, old);
        push_train(0, t + 2, 3, 1);
        tick(1);
        expect_status(0, 1'b0, 1'b1, 1'b1, 1'b0, old);
        tick(1);
        expect_status(0, 1'b0, 1'b1, 1'b0, 1'b0, (old + 1) % 4);
        tick(5);
        expect_status(0, 1'b0, 1'b0, 1'b0, 1'b1, base[0]);
        rv[0] = 1'b0;
        tick(1);
        expect_status(0, 1'b1, 1'b0, 1'b0, 1'b0, base[0]);
        tick(1);

        // Wide gap, maximum count.
        request(1, 15, 3);
        tick(1);

        // Reset in the cycle of the second strobe.
        old   = base[0];
        rc    = 4'd4;
        rv[0] = 1'b1;
        t     = edge_n + 1;
        push_ev(t + 1, 0, 1'b0, old);
        push_ev(t + 3, 0, 1'b0, (old + 1) % 4);
        tick(1);
        rv[0] = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        base[0] = 0;
        base[1] = 0;
        expect_status(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick(6);
        request(0, 2, 1);

        tick(2);
        end_req = 1'b1;
        tick(5);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int  cur;
        int  sv;
        st_t s;
        ev_t e;
        cur = edge_n + 1;

        while (st_q.size() > 0 && st_q[0].cyc <= cur) begin
            s  = st_q.pop_front();
            sv = (s.id == 0) ? int'(sent_a) : int'(sent_b);
            n_vec++;
            if (s.cyc != cur || rdy[s.id] !== s.ready || bsy[s.id] !== s.busy ||
                strb[s.id] !== s.strobe || dn[s.id] !== s.done || sv != s.sent) begin
                n_miss++;
                $display("FAIL status dut%0d cyc %0d: got rdy=%b busy=%b strb=%b done=%b sent=%0d, want cyc %0d rdy=%b busy=%b strb=%b done=%b sent=%0d",
                         s.id, cur, rdy[s.id], bsy[s.id], strb[s.id], dn[s.id], sv,
                         s.cyc, s.ready, s.busy, s.strobe, s.done, s.sent);
            end
        end

        for (int i = 0; i < 2; i++) begin
            sv = (i == 0) ? int'(sent_a) : int'(sent_b);
            if (strb[i] === 1'b1 || dn[i] === 1'b1) begin
                n_vec++;
                if (ev_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL event dut%0d cyc %0d: got strb=%b done=%b, want no output",
                             i, cur, strb[i], dn[i]);
                end else begin
                    e = ev_q.pop_front();
                    if (e.id != i || e.cyc != cur || bit'(dn[i]) != e.is_done ||
                        bit'(strb[i]) == e.is_done || sv != e.sent ||
                        (e.is_done && rx[i] != sv)) begin
                        n_miss++;
                        $display("FAIL event dut%0d cyc %0d: got done=%b strb=%b sent=%0d rx=%0d, want dut%0d cyc %0d done=%b sent=%0d",
                                 i, cur, dn[i], strb[i], sv, rx[i], e.id, e.cyc, e.is_done, e.sent);
                    end
                end
            end
            // Paired receiver: counts rising edges of the strobe, modulo 4.
            if (rst) rx[i] = 0;
            else if (strb[i] === 1'b1 && !prev_strb[i]) rx[i] = (rx[i] + 1) % 4;
            prev_strb[i] = (strb[i] === 1'b1);
        end

        if (end_req) begin
            n_vec++;
            if (ev_q.size() != 0 || st_q.size() != 0) begin
                n_miss++;
                $display("FAIL drain: got %0d events and %0d status entries pending, want 0 and 0",
                         ev_q.size(), st_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
            $finish;
        end
    end

    initial begin
        rx[0] = 0;
        rx[1] = 0;
        prev_strb[0] = 1'b0;
        prev_strb[1] = 1'b0;
    end

endmodule
